ssp_arbiter: RTL and testbench

SSP_ARBITER -- requirements
Module: ssp_arbiter

---
 rtl/ssp_pkg.sv | 20 ++
 rtl/ssp_arb_pick.sv | 29 ++
 rtl/ssp_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ssp_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP processor-interface arbiter.
package ssp_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStall  = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } ssp_state_e;

   localparam int unsigned StallLimitDefault = 64;

   // Stall counter is at least 8 bits wide and always wide enough to hold the limit.
   function automatic int unsigned stall_cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/ssp_arb_pick.sv
// Combinational winner selection: round-robin between two requesters, with an
// RX-full override that favours a lone reader so the RX FIFO drains.
module ssp_arb_pick (
   input  logic [1:0] valid_i,
   input  logic [1:0] write_i,
   input  logic       rx_full_i,
   input  logic       last_i,
   output logic       win_o,
   output logic       any_o
);

   logic one_reader;

   always_comb begin
      one_reader = write_i[0] ^ write_i[1];
      any_o      = |valid_i;
      if (valid_i == 2'b11) begin
         // With exactly one reader, index of the reader equals write_i[0].
         if (rx_full_i && one_reader) begin
            win_o = write_i[0];
         end else begin
            win_o = ~last_i;
         end
      end else begin
         win_o = valid_i[1];
      end
   end

endmodule

// File: rtl/ssp_arbiter.sv
// Two-requester arbiter in front of an SSP processor interface.
// Optional TX-stall watchdog enabled by defining SSP_ARB_WDT_EN.
module ssp_arbiter
   import ssp_pkg::*;
#(
   parameter int unsigned STALL_LIMIT = StallLimitDefault
) (
   input  logic       PCLK,
   input  logic       CLEAR_B,
   input  logic       REQ0_VALID,
   input  logic       REQ0_WRITE,
   input  logic [7:0] REQ0_WDATA,
   output logic       REQ0_READY,
   output logic [7:0] REQ0_RDATA,
   output logic       REQ0_ERR,
   input  logic       REQ1_VALID,
   input  logic       REQ1_WRITE,
   input  logic [7:0] REQ1_WDATA,
   output logic       REQ1_READY,
   output logic [7:0] REQ1_RDATA,
   output logic       REQ1_ERR,
   output logic       PSEL,
   output logic       PWRITE,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       SSPTXINTR,
   input  logic       SSPRXINTR
);

   ssp_state_e state_q, state_d;
   logic       win_q, win_d;
   logic       last_q, last_d;
   logic       psel_q, psel_d;
   logic       pwrite_q, pwrite_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic [1:0] ready_q, ready_d;
   logic [7:0] rdata_q, rdata_d;

   logic [1:0] valid;
   logic [1:0] write;
   logic       pick_win;
   logic       pick_any;
   logic [7:0] wdata_pick;
   logic [7:0] wdata_held;

   assign valid = {REQ1_VALID, REQ0_VALID};
   assign write = {REQ1_WRITE, REQ0_WRITE};

   ssp_arb_pick u_pick (
      .valid_i   (valid),
      .write_i   (write),
      .rx_full_i (SSPRXINTR),
      .last_i    (last_q),
      .win_o     (pick_win),
      .any_o     (pick_any)
   );

`ifdef SSP_ARB_WDT_EN
   localparam int unsigned CntW = stall_cnt_width(STALL_LIMIT);
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]      err_q, err_d;
   assign cnt_inc = cnt_q + CntW'(1);
`else
   logic unused_stall_limit;
   assign unused_stall_limit = ^STALL_LIMIT;
`endif

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      last_d     = last_q;
      psel_d     = 1'b0;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      ready_d    = 2'b00;
      rdata_d    = rdata_q;
      wdata_pick = pick_win ? REQ1_WDATA : REQ0_WDATA;
      wdata_held = win_q ? REQ1_WDATA : REQ0_WDATA;
`ifdef SSP_ARB_WDT_EN
      cnt_d      = cnt_q;
      err_d      = 2'b00;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef SSP_ARB_WDT_EN
            cnt_d = '0;
`endif
            if (pick_any) begin
               win_d  = pick_win;
               last_d = pick_win;
               if (write[pick_win] && SSPTXINTR) begin
                  state_d = StStall;
               end else begin
                  state_d  = StAccess;
                  psel_d   = 1'b1;
                  pwrite_d = write[pick_win];
                  pwdata_d = wdata_pick;
               end
            end
         end
         StStall: begin
            if (!SSPTXINTR) begin
               state_d  = StAccess;
               psel_d   = 1'b1;
               pwrite_d = write[win_q];
               pwdata_d = wdata_held;
`ifdef SSP_ARB_WDT_EN
            end else if (cnt_inc >= CntW'(STALL_LIMIT)) begin
               // Give up on the write: complete it with an error and no PSEL.
               state_d        = StResp;
               ready_d[win_q] = 1'b1;
               err_d[win_q]   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
`endif
            end
         end
         StAccess: begin
            state_d        = StResp;
            ready_d[win_q] = 1'b1;
            if (!pwrite_q) begin
               rdata_d = PRDATA;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         state_q  <= StIdle;
         win_q    <= 1'b0;
         last_q   <= 1'b1;
         psel_q   <= 1'b0;
         pwrite_q <= 1'b0;
         pwdata_q <= 8'h00;
         ready_q  <= 2'b00;
         rdata_q  <= 8'h00;
`ifdef SSP_ARB_WDT_EN
         cnt_q    <= '0;
         err_q    <= 2'b00;
`endif
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         last_q   <= last_d;
         psel_q   <= psel_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
`ifdef SSP_ARB_WDT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign PSEL       = psel_q;
   assign PWRITE     = pwrite_q;
   assign PWDATA     = pwdata_q;
   assign REQ0_READY = ready_q[0];
   assign REQ1_READY = ready_q[1];
   assign REQ0_RDATA = rdata_q;
   assign REQ1_RDATA = rdata_q;
`ifdef SSP_ARB_WDT_EN
   assign REQ0_ERR   = err_q[0];
   assign REQ1_ERR   = err_q[1];
`else
   assign REQ0_ERR   = 1'b0;
   assign REQ1_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_arbiter.sv
// Self-checking bench for ssp_arbiter: vector table, corner-case sequences and a
// randomized run against a cycle-timeline reference model.
module tb_ssp_arbiter;

   localparam int unsigned StallLimit = 4;
`ifdef SSP_ARB_WDT_EN
   localparam int TxHold = 3;
`else
   localparam int TxHold = 10;
`endif

   logic       pclk = 1'b0;
   logic       clear_b;
   logic       req0_valid, req0_write, req0_ready, req0_err;
   logic [7:0] req0_wdata, req0_rdata;
   logic       req1_valid, req1_write, req1_ready, req1_err;
   logic [7:0] req1_wdata, req1_rdata;
   logic       psel, pwrite;
   logic [7:0] pwdata, prdata;
   logic       ssptxintr, ssprxintr;

   int n_tests = 0;
   int n_fail  = 0;

   ssp_arbiter #(
      .STALL_LIMIT (StallLimit)
   ) dut (
      .PCLK       (pclk),
      .CLEAR_B    (clear_b),
      .REQ0_VALID (req0_valid),
      .REQ0_WRITE (req0_write),
      .REQ0_WDATA (req0_wdata),
      .REQ0_READY (req0_ready),
      .REQ0_RDATA (req0_rdata),
      .REQ0_ERR   (req0_err),
      .REQ1_VALID (req1_valid),
      .REQ1_WRITE (req1_write),
      .REQ1_WDATA (req1_wdata),
      .REQ1_READY (req1_ready),
      .REQ1_RDATA (req1_rdata),
      .REQ1_ERR   (req1_err),
      .PSEL       (psel),
      .PWRITE     (pwrite),
      .PWDATA     (pwdata),
      .PRDATA     (prdata),
      .SSPTXINTR  (ssptxintr),
      .SSPRXINTR  (ssprxintr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit         v0, v1, w0, w1;
      logic [7:0] d0, d1;
      bit         rx;
      logic [7:0] prd;
      int         first;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic smp();
      @(negedge pclk);
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_write = 0; req0_wdata = 0;
      req1_valid = 0; req1_write = 0; req1_wdata = 0;
      ssptxintr  = 0; ssprxintr  = 0; prdata     = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      clear_b = 0;
      step();
      step();
      clear_b = 1;
      step();
   endtask

   // Starts in an IDLE cycle with the request already presented.
   task automatic expect_txn(input string nm, input int who, input bit wr,
                             input logic [7:0] d, input logic [7:0] rd_exp);
      smp();
      chk({nm, " idle psel"}, {31'd0, psel}, 0);
      step();
      smp();
      chk({nm, " access"}, {psel, pwrite, pwdata, req1_ready, req0_ready},
          {1'b1, wr, d, 2'b00});
      step();
      smp();
      chk({nm, " resp"}, {req1_ready, req0_ready, psel, req1_err, req0_err},
          {(who == 1), (who == 0), 3'b000});
      if (!wr) chk({nm, " rdata"}, (who == 1) ? req1_rdata : req0_rdata, rd_exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      bit         pend[2];
      bit         pw[2];
      logic [7:0] pd[2];
      bit         seen[2];
      bit         in_txn, stalling, resp_err, gwr, exp_psel;
      int         gw, last, acc_at, resp_at, nstall;
      logic [7:0] gd, mdl_rdata;
      logic [1:0] exp_r;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 8'h3C, 1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h88, 1'b1, 8'hE1, 0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h00, 0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h69, 0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42, 0};
      vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 8'h00, 1};

      // Reset values while CLEAR_B is held low.
      idle_inputs();
      clear_b = 1;
      #1 clear_b = 0;
      #2;
      chk("reset outputs", {psel, pwrite, pwdata, req0_ready, req1_ready, req0_rdata,
                            req1_rdata, req0_err, req1_err}, 0);
      step();
      step();
      clear_b = 1;
      step();

      // Vector table; the loser of a contended row is served right after the winner.
      for (int i = 0; i < 9; i++) begin
         int   f;
         int   s;
         req0_valid = vecs[i].v0; req0_write = vecs[i].w0; req0_wdata = vecs[i].d0;
         req1_valid = vecs[i].v1; req1_write = vecs[i].w1; req1_wdata = vecs[i].d1;
         ssprxintr  = vecs[i].rx; prdata     = vecs[i].prd;
         f = vecs[i].first;
         s = 1 - f;
         expect_txn($sformatf("vec%0d first", i), f, f ? vecs[i].w1 : vecs[i].w0,
                    f ? vecs[i].d1 : vecs[i].d0, vecs[i].prd);
         step();
         if (vecs[i].v0 && vecs[i].v1) begin
            if (f == 1) req1_valid = 0;
            else        req0_valid = 0;
            expect_txn($sformatf("vec%0d second", i), s, s ? vecs[i].w1 : vecs[i].w0,
                       s ? vecs[i].d1 : vecs[i].d0, vecs[i].prd);
            step();
         end
         idle_inputs();
         step();
      end

      // Continuous contention: grants alternate 0,1,0,1 three cycles apart.
      do_reset();
      req0_valid = 1;
      req1_valid = 1;
      for (int k = 0; k < 13; k++) begin
         bit e0, e1;
         smp();
         e0 = (k >= 2) && ((k - 2) % 3 == 0) && (((k - 2) / 3) % 2 == 0);
         e1 = (k >= 2) && ((k - 2) % 3 == 0) && (((k - 2) / 3) % 2 == 1);
         chk($sformatf("contend k%0d", k), {req1_ready, req0_ready}, {e1, e0});
         step();
      end

      // TX FIFO full: no PSEL until the cycle after SSPTXINTR drops.
      do_reset();
      req1_valid = 1; req1_write = 1; req1_wdata = 8'h5E; ssptxintr = 1;
      for (int k = 0; k < TxHold; k++) begin
         smp();
         chk($sformatf("txfull k%0d", k), {psel, req1_ready, req0_ready}, 0);
         step();
      end
      ssptxintr = 0;
      smp();
      chk("txfull drop cycle", {31'd0, psel}, 0);
      step();
      smp();
      chk("txfull access", {psel, pwrite, pwdata}, {2'b11, 8'h5E});
      step();
      smp();
      chk("txfull ready", {req1_ready, req0_ready, req1_err}, 3'b100);
      step();
      idle_inputs();

      // Stall watchdog.
      do_reset();
      req0_valid = 1; req0_write = 1; req0_wdata = 8'h99; ssptxintr = 1;
`ifdef SSP_ARB_WDT_EN
      for (int k = 0; k < 5; k++) begin
         smp();
         chk($sformatf("wdt wait k%0d", k), {psel, req0_ready, req0_err}, 0);
         step();
      end
      smp();
      chk("wdt timeout", {req0_ready, req0_err, psel, req1_ready}, 4'b1100);
      step();
      idle_inputs();
`else
      for (int k = 0; k < 20; k++) begin
         smp();
         chk($sformatf("nowdt wait k%0d", k), {psel, req0_ready, req0_err}, 0);
         step();
      end
      ssptxintr = 0;
      step();
      smp();
      chk("nowdt access", {psel, pwrite, pwdata}, {2'b11, 8'h99});
      step();
      smp();
      chk("nowdt ready", {req0_ready, req0_err}, 2'b10);
      step();
      idle_inputs();
`endif

      // Reset during ACCESS.
      do_reset();
      req1_valid = 1; prdata = 8'h12;
      step();
      chk("mid-reset access psel", {31'd0, psel}, 1);
      #2 clear_b = 0;
      #1 chk("async psel drop", {31'd0, psel}, 0);
      step();
      smp();
      chk("no ready in reset", {req1_ready, req0_ready}, 0);
      step();
      clear_b = 1;
      idle_inputs();
      req0_valid = 1; req0_write = 1; req0_wdata = 8'hAB;
      req1_valid = 1; req1_write = 1; req1_wdata = 8'hCD;
      expect_txn("post reset", 0, 1'b1, 8'hAB, 8'h00);
      step();

      // Randomized run against the timeline model.
      do_reset();
      pend = '{0, 0}; pw = '{0, 0}; pd = '{0, 0}; seen = '{0, 0};
      in_txn = 0; stalling = 0; resp_err = 0; gwr = 0; gw = 0; gd = 0;
      last = 1; acc_at = -1; resp_at = -1; nstall = 0; mdl_rdata = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (seen[i]) pend[i] = 0;
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               pw[i]   = 1'($urandom_range(0, 1));
               pd[i]   = 8'($urandom);
            end
         end
         req0_valid = pend[0]; req0_write = pw[0]; req0_wdata = pd[0];
         req1_valid = pend[1]; req1_write = pw[1]; req1_wdata = pd[1];
         ssptxintr  = ($urandom_range(0, 3) == 0);
         ssprxintr  = 1'($urandom_range(0, 1));
         prdata     = 8'($urandom);
         smp();
         exp_psel = (c == acc_at);
         exp_r    = {(c == resp_at) && (gw == 1), (c == resp_at) && (gw == 0)};
         chk($sformatf("rand ctl c%0d", c), {psel, req1_ready, req0_ready, req1_err, req0_err},
             {exp_psel, exp_r, exp_r & {2{resp_err}}});
         if (exp_psel) chk($sformatf("rand pdata c%0d", c), {pwrite, pwdata}, {gwr, gd});
         if (exp_psel && !gwr) mdl_rdata = prdata;
         if (c == resp_at)
            chk($sformatf("rand rdata c%0d", c), (gw == 1) ? req1_rdata : req0_rdata, mdl_rdata);
         seen[0] = req0_ready;
         seen[1] = req1_ready;
         if (c == resp_at) begin
            in_txn = 0;
         end else if (!in_txn) begin
            if (pend[0] || pend[1]) begin
               if (pend[0] && pend[1]) begin
                  if (ssprxintr && (pw[0] != pw[1])) gw = pw[0] ? 1 : 0;
                  else                               gw = 1 - last;
               end else begin
                  gw = pend[1] ? 1 : 0;
               end
               last     = gw;
               gwr      = pw[gw];
               gd       = pd[gw];
               resp_err = 0;
               in_txn   = 1;
               if (gwr && ssptxintr) begin
                  stalling = 1;
                  nstall   = 0;
               end else begin
                  acc_at  = c + 1;
                  resp_at = c + 2;
               end
            end
         end else if (stalling) begin
            if (!ssptxintr) begin
               stalling = 0;
               acc_at   = c + 1;
               resp_at  = c + 2;
            end else begin
               nstall++;
`ifdef SSP_ARB_WDT_EN
               if (nstall >= StallLimit) begin
                  stalling = 0;
                  resp_err = 1;
                  resp_at  = c + 1;
               end
`endif
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
